// File: rtl/agc_pkg.sv
// ============================================================================
// Module   : agc_pkg
// Purpose  : Shared widths, unity-gain helper and gain FSM states for the
//            AGC gain-apply block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package agc_pkg;

  localparam int GAIN_W   = 24;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    TRACK  = 2'd1,
    FREEZE = 2'd2
  } gain_state_e;

  function automatic logic [GAIN_W-1:0] unity_gain(input int frac);
    logic [GAIN_W-1:0] one;
    one = {{(GAIN_W-1){1'b0}}, 1'b1};
    return one << frac;
  endfunction

endpackage

`default_nettype wire

// File: rtl/agc_gain_scale.sv
// ============================================================================
// Module   : agc_gain_scale
// Purpose  : One rail: signed sample x unsigned gain, round-half-up,
//            saturate to SAMPLE_W signed. Two register stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module agc_gain_scale
  import agc_pkg::*;
#(
  parameter int GAIN_FRAC = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic        [GAIN_W-1:0]   gain_i,
  output logic signed [SAMPLE_W-1:0] data_o,
  output logic                       sat_o
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1) << (GAIN_FRAC - 1);
  localparam logic signed [PROD_W-1:0] MAX_C   = PROD_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] MIN_C   = ~MAX_C;

  logic signed [PROD_W-1:0]   w_a;
  logic signed [PROD_W-1:0]   w_b;
  logic signed [PROD_W-1:0]   w_rnd;
  logic signed [PROD_W-1:0]   w_shr;
  logic signed [PROD_W-1:0]   prod_d, prod_q;
  logic signed [SAMPLE_W-1:0] data_d, data_q;
  logic                       sat_d, sat_q;

  always_comb begin
    w_a    = PROD_W'(sample_i);
    w_b    = PROD_W'({1'b0, gain_i});
    prod_d = w_a * w_b;
    // Adding half an LSB before the arithmetic shift gives round-half-up.
    w_rnd  = prod_q + ROUND_C;
    w_shr  = w_rnd >>> GAIN_FRAC;
    sat_d  = 1'b0;
    data_d = w_shr[SAMPLE_W-1:0];
    if (w_shr > MAX_C) begin
      data_d = MAX_C[SAMPLE_W-1:0];
      sat_d  = 1'b1;
    end else if (w_shr < MIN_C) begin
      data_d = MIN_C[SAMPLE_W-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      prod_q <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign data_o = data_q;
  assign sat_o  = sat_q;

endmodule

`default_nettype wire

// File: rtl/agc_gain_apply.sv
// ============================================================================
// Module   : agc_gain_apply
// Purpose  : Slew-limited application of the AGC gain word to I/Q samples.
//            Optional saturation counter under AGC_APPLY_SAT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module agc_gain_apply
  import agc_pkg::*;
#(
  parameter int                GAIN_FRAC     = 16,
  parameter logic [GAIN_W-1:0] MAX_STEP      = 24'h001000,
  parameter int                UPDATE_PERIOD = 4,
  parameter int                SETTLE_CYCLES = 128
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] data_in_I,
  input  logic signed [SAMPLE_W-1:0] data_in_Q,
  input  logic        [GAIN_W-1:0]   gain_in,
  input  logic                       freeze,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] data_out_I,
  output logic signed [SAMPLE_W-1:0] data_out_Q,
  output logic        [GAIN_W-1:0]   gain_applied,
  output logic                       sat
`ifdef AGC_APPLY_SAT_CNT_EN
  ,
  input  logic                       sat_clr,
  output logic        [15:0]         sat_count
`endif
);

  localparam logic [GAIN_W-1:0]   UNITY    = unity_gain(GAIN_FRAC);
  localparam int                  SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int                  UPD_W    = $clog2(UPDATE_PERIOD + 1);
  localparam logic signed [GAIN_W:0] STEP_POS = {1'b0, MAX_STEP};
  localparam logic signed [GAIN_W:0] STEP_NEG = -STEP_POS;

  gain_state_e          state_q;
  logic [GAIN_W-1:0]    gain_q, gain_d;
  logic [SETTLE_W-1:0]  settle_q;
  logic [UPD_W-1:0]     upd_q;
  logic signed [GAIN_W:0] w_diff, w_step;
  logic                 w_tick;

  always_comb begin
    w_diff = $signed({1'b0, gain_in}) - $signed({1'b0, gain_q});
    if (w_diff > STEP_POS) begin
      w_step = STEP_POS;
    end else if (w_diff < STEP_NEG) begin
      w_step = STEP_NEG;
    end else begin
      w_step = w_diff;
    end
    gain_d = gain_q + w_step[GAIN_W-1:0];
    w_tick = (upd_q == UPD_W'(UPDATE_PERIOD - 1));
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q  <= INIT;
      gain_q   <= UNITY;
      settle_q <= '0;
      upd_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state_q <= TRACK;
            upd_q   <= '0;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        TRACK: begin
          // freeze takes priority over a coincident update tick
          if (freeze) begin
            state_q <= FREEZE;
          end else if (w_tick) begin
            gain_q <= gain_d;
            upd_q  <= '0;
          end else begin
            upd_q <= upd_q + 1'b1;
          end
        end
        FREEZE: begin
          if (!freeze) begin
            state_q <= TRACK;
            upd_q   <= '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  logic                       vld1_q, vld2_q, vld3_q;
  logic signed [SAMPLE_W-1:0] i1_q, q1_q;
  logic [GAIN_W-1:0]          g1_q;

  // Gain is captured alongside both rails so an I/Q pair shares one gain.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      vld3_q <= 1'b0;
      i1_q   <= '0;
      q1_q   <= '0;
      g1_q   <= UNITY;
    end else begin
      vld1_q <= in_valid;
      vld2_q <= vld1_q;
      vld3_q <= vld2_q;
      i1_q   <= data_in_I;
      q1_q   <= data_in_Q;
      g1_q   <= gain_q;
    end
  end

  logic w_sat_i, w_sat_q;

  agc_gain_scale #(.GAIN_FRAC(GAIN_FRAC)) u_scale_i (
    .clk      (clk),
    .arst     (arst),
    .sample_i (i1_q),
    .gain_i   (g1_q),
    .data_o   (data_out_I),
    .sat_o    (w_sat_i)
  );

  agc_gain_scale #(.GAIN_FRAC(GAIN_FRAC)) u_scale_q (
    .clk      (clk),
    .arst     (arst),
    .sample_i (q1_q),
    .gain_i   (g1_q),
    .data_o   (data_out_Q),
    .sat_o    (w_sat_q)
  );

  assign out_valid    = vld3_q;
  assign sat          = w_sat_i | w_sat_q;
  assign gain_applied = gain_q;

`ifdef AGC_APPLY_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sat_cnt_q <= '0;
    end else if (sat_clr) begin
      sat_cnt_q <= '0;
    end else if (out_valid && sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_agc_gain_apply.sv
// ============================================================================
// Module   : tb_agc_gain_apply
// Purpose  : Directed vector bench for agc_gain_apply (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_agc_gain_apply;

  logic               clk = 1'b0;
  logic               arst;
  logic               in_valid;
  logic signed [15:0] din_i, din_q;
  logic [23:0]        gain_in;
  logic               freeze;
  logic               out_valid;
  logic signed [15:0] dout_i, dout_q;
  logic [23:0]        gain_applied;
  logic               sat;
`ifdef AGC_APPLY_SAT_CNT_EN
  logic               sat_clr = 1'b0;
  logic [15:0]        sat_count;
`endif

  int checks   = 0;
  int failures = 0;
  int m        = 0;

  always #5 clk = ~clk;

  agc_gain_apply dut (
    .clk          (clk),
    .arst         (arst),
    .in_valid     (in_valid),
    .data_in_I    (din_i),
    .data_in_Q    (din_q),
    .gain_in      (gain_in),
    .freeze       (freeze),
    .out_valid    (out_valid),
    .data_out_I   (dout_i),
    .data_out_Q   (dout_q),
    .gain_applied (gain_applied),
    .sat          (sat)
`ifdef AGC_APPLY_SAT_CNT_EN
    ,
    .sat_clr      (sat_clr),
    .sat_count    (sat_count)
`endif
  );

  typedef struct {
    logic               vld;
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               evld;
    logic signed [15:0] ei;
    logic signed [15:0] eq;
    logic               esat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input int i, input int q,
                              input logic ev, input int ei, input int eq, input logic es);
    vec_t r;
    r.vld  = v;
    r.i    = 16'(i);
    r.q    = 16'(q);
    r.evld = ev;
    r.ei   = 16'(ei);
    r.eq   = 16'(eq);
    r.esat = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    m++;
  endtask

  task automatic wait_m(input int target);
    while (m < target) tick();
  endtask

  task automatic wait_gain(input logic [23:0] target, input int budget, input string name);
    int cnt = 0;
    while (gain_applied !== target && cnt < budget) begin
      tick();
      cnt++;
    end
    chk(name, gain_applied, target);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, out_valid, 1'b0);
    chk({tag, ".data_I"}, dout_i, 16'sd0);
    chk({tag, ".data_Q"}, dout_q, 16'sd0);
    chk({tag, ".sat"}, sat, 1'b0);
    chk({tag, ".gain"}, gain_applied, 24'h010000);
  endtask

  // Streams tbl one sample per cycle; each result is checked 3 cycles later.
  task automatic run_table(input string name);
    int n = tbl.size();
    for (int k = 0; k < n + 3; k++) begin
      if (k >= 3) begin
        chk($sformatf("%s[%0d].valid", name, k - 3), out_valid, tbl[k-3].evld);
        if (tbl[k-3].evld) begin
          chk($sformatf("%s[%0d].I", name, k - 3), dout_i, tbl[k-3].ei);
          chk($sformatf("%s[%0d].Q", name, k - 3), dout_q, tbl[k-3].eq);
          chk($sformatf("%s[%0d].sat", name, k - 3), sat, tbl[k-3].esat);
        end
      end
      if (k < n) begin
        in_valid = tbl[k].vld;
        din_i    = tbl[k].i;
        din_q    = tbl[k].q;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    tbl.delete();
  endtask

  initial begin
    arst     = 1'b0;
    in_valid = 1'b0;
    din_i    = '0;
    din_q    = '0;
    gain_in  = 24'h020000;
    freeze   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    arst = 1'b1;
    m    = 0;

    // Unity gain while INIT runs
    tbl.push_back(mk(1, 1000, -1000, 1, 1000, -1000, 0));
    tbl.push_back(mk(1, 32767, -32768, 1, 32767, -32768, 0));
    tbl.push_back(mk(0, 555, 555, 0, 0, 0, 0));
    tbl.push_back(mk(1, -1, 1, 1, -1, 1, 0));
    tbl.push_back(mk(1, 12345, -54, 1, 12345, -54, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0));
    run_table("unity");

    // freeze during INIT must not delay the TRACK entry
    freeze = 1'b1;
    wait_m(127);
    freeze = 1'b0;
    wait_m(131);
    chk("init_hold", gain_applied, 24'h010000);
    tick();
    chk("first_update", gain_applied, 24'h011000);
    wait_m(135);
    chk("slew_pre2", gain_applied, 24'h011000);
    tick();
    chk("slew_2", gain_applied, 24'h012000);
    wait_m(191);
    chk("slew_15", gain_applied, 24'h01F000);
    tick();
    chk("slew_16", gain_applied, 24'h020000);
    wait_m(204);
    chk("no_overshoot", gain_applied, 24'h020000);

    // Gain 2.0
    tbl.push_back(mk(1, 20000, -20000, 1, 32767, -32768, 1));
    tbl.push_back(mk(1, 100, -100, 1, 200, -200, 0));
    tbl.push_back(mk(1, 16383, 0, 1, 32766, 0, 0));
    tbl.push_back(mk(1, 16384, -16384, 1, 32767, -32768, 1));
    tbl.push_back(mk(1, -16385, 1, 1, -32768, 2, 1));
    tbl.push_back(mk(1, -16384, 7, 1, -32768, 14, 0));
    run_table("sat");

    // Gain 0.5
    gain_in = 24'h008000;
    wait_gain(24'h008000, 300, "ramp_half");
    tbl.push_back(mk(1, 3, -3, 1, 2, -1, 0));
    tbl.push_back(mk(1, -32768, 5, 1, -16384, 3, 0));
    tbl.push_back(mk(1, -5, 1, 1, -2, 1, 0));
    tbl.push_back(mk(1, 32767, -1, 1, 16384, 0, 0));
    run_table("round");

    // Reset asserted while the pipe holds valid samples
    in_valid = 1'b1;
    din_i    = 16'sd1000;
    din_q    = -16'sd1000;
    repeat (3) tick();
    chk("pre_rst.valid", out_valid, 1'b1);
    chk("pre_rst.I", dout_i, 16'sd500);
    arst = 1'b0;
    #1;
    chk_reset("midrst");
    in_valid = 1'b0;
    gain_in  = 24'h000000;
    repeat (2) tick();
    arst = 1'b1;
    m    = 0;
    wait_m(3);
    chk("post_rst.valid", out_valid, 1'b0);
    wait_m(131);
    chk("reinit_hold", gain_applied, 24'h010000);
    tick();
    chk("reinit_update", gain_applied, 24'h00F000);

    // Freeze mid-ramp toward 0
    freeze = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("frozen[%0d]", k), gain_applied, 24'h00F000);
    end
    freeze = 1'b0;
    wait_m(156);
    chk("unfreeze_hold", gain_applied, 24'h00F000);
    tick();
    chk("unfreeze_resume", gain_applied, 24'h00E000);

    wait_gain(24'h000000, 300, "ramp_zero");
    repeat (8) tick();
    chk("zero_floor", gain_applied, 24'h000000);
    tbl.push_back(mk(1, 1000, -1000, 1, 0, 0, 0));
    tbl.push_back(mk(1, -32768, 32767, 1, 0, 0, 0));
    run_table("zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/agc_gain_apply.md
# agc_gain_apply

Applies the gain word produced by the automatic gain control loop to the I/Q sample stream. It sits directly downstream of the AGC and its divider. The applied gain slews toward the AGC target at a bounded rate, so loop noise does not reach the datapath. Each sample is multiplied by the applied gain, rounded, and saturated to 16-bit signed. Output feeds the demodulator front end.

## Interface
- GAIN_FRAC, 16: fractional bits of the unsigned gain word (unity = 1<<GAIN_FRAC)
- MAX_STEP, 24'h001000: largest change of the applied gain per update
- UPDATE_PERIOD, 4: cycles between gain updates (≥1)
- SETTLE_CYCLES, 128: cycles held at unity after reset, covering AGC average fill and divider latency
- clk  in  1  sole clock, rising edge
- arst  in  1  asynchronous, active-low reset
- in_valid  in  1  sample qualifier
- data_in_I / data_in_Q  in  16 each  signed samples
- gain_in  in  24  unsigned target gain from the AGC divider
- freeze  in  1  hold the applied gain (e.g. during a packet)
- out_valid  out  1  output qualifier
- data_out_I / data_out_Q  out  16 each  signed scaled samples
- gain_applied  out  24  current applied gain
- sat  out  1  I or Q saturated on this output sample

## Operation
- Gain FSM states:
  - INIT: applied gain = unity; counter runs SETTLE_CYCLES, then go to TRACK.
  - TRACK: every UPDATE_PERIOD cycles, applied += clamp(gain_in − applied, −MAX_STEP, +MAX_STEP). The difference is computed at 25-bit signed width.
  - FREEZE: applied gain held; update counter held.
- Transitions: TRACK→FREEZE when freeze=1; FREEZE→TRACK when freeze=0. freeze is ignored in INIT; INIT always completes.
- Update counter restarts at 0 on entry to TRACK. First update fires UPDATE_PERIOD cycles after entry.
- If applied is within MAX_STEP of the target, the update lands exactly on the target with no overshoot.
- gain_in=0 is legal: the applied gain ramps toward 0.
- Datapath for each of I and Q:
  - product = sample (16b signed) × {1'b0, gain} (25b signed) → 41b signed.
  - Add 1<<(GAIN_FRAC−1), then arithmetic shift right by GAIN_FRAC. This is round-half-up, so −1.5 gives −1.
  - Saturate to [−32768, 32767]. sat = saturation on I OR on Q.
- Each product uses the applied gain sampled in the same cycle as its input sample. A gain change never splits an I/Q pair.
- No backpressure. Samples with in_valid=0 still flow through the pipe, but their out_valid is 0.

## Timing
- Latency is 3 cycles, in_valid to out_valid: input register, multiply register, round/saturate register.
- Throughput: one sample per cycle.
- Reset values: out_valid=0, data_out_I=0, data_out_Q=0, sat=0, gain_applied=unity, FSM=INIT, all counters 0.
- Reset asserted mid-stream clears the pipe immediately. Samples in flight are dropped.
- freeze and an update tick in the same cycle: freeze wins, no update.
- gain_applied changes on the clock edge after an update tick.

## Configuration
- AGC_APPLY_SAT_CNT_EN defined:
  - Adds output sat_count [15:0]. It increments on every out_valid sample with sat=1 and saturates at 16'hFFFF.
  - Adds input sat_clr, which clears the count synchronously. If sat_clr and an increment coincide, the count becomes 0.
  - Reset value of sat_count is 0.
- Undefined: neither port exists and no counter logic is built.

## Structure
- Shared package agc_pkg holds:
  - GAIN_W=24, SAMPLE_W=16
  - the unity-gain constant function of GAIN_FRAC
  - the gain FSM state enum (INIT, TRACK, FREEZE)
- One sub-module, agc_gain_scale: multiply/round/saturate for one rail, instantiated twice (I and Q). The FSM and slew logic stay in the top.

## Test plan
- Unity gain after reset: during INIT, in_valid=1 with I=1000, Q=−1000 → output 1000/−1000 three cycles later, sat=0, gain_applied=24'h010000.
- Saturation: force gain to 24'h020000 (2.0); I=20000 → 32767 and Q=−20000 → −32768, both with sat=1.
- Rounding with gain 24'h008000 (0.5):
  - I=3 → 2; Q=−3 → −1.
  - I=−32768 → −16384, sat=0.
- Slew: after INIT, gain_in=24'h030000 with MAX_STEP=24'h001000 and UPDATE_PERIOD=4 → gain_applied rises by 24'h001000 every 4 cycles and settles at 24'h030000 after 32 updates, no overshoot.
- Freeze: assert freeze mid-ramp with target 0 → gain_applied constant while freeze=1, ramp resumes 4 cycles after release; freeze during INIT has no effect.
- Reset mid-stream: drop arst while out_valid=1 → all outputs return to reset values immediately; after release, INIT repeats for 128 cycles.
